// File: rtl/vga_pkg.sv
// Shared pong definitions: game-state encoding used by the sequencer and the text overlay.
// Latency: n/a (types only).
// Backpressure: n/a.
package vga_pkg;

    // The overlay renderer draws nothing for GAME_PLAY and SERVE_WAIT.
    typedef enum logic [1:0] {
        MENU_START = 2'b00,
        GAME_PLAY  = 2'b01,
        GAME_OVER  = 2'b10,
        SERVE_WAIT = 2'b11
    } game_state_t;

    localparam int SCORE_W = 4;

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Frame timer: vblnk rising-edge detector plus a loadable frame down-counter.
// Latency: load takes effect next clk; expire is combinational on the final frame tick.
// Backpressure: none; free-running on vblnk.
module frame_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vblnk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done,
    output logic         expire
);

    logic         vblnk_q;
    logic         frame_tick;
    logic [W-1:0] cnt;

    // Delay vblnk by one cycle so its rising edge yields a single-cycle tick.
    always_ff @(posedge clk) begin
        if (rst) vblnk_q <= 1'b0;
        else     vblnk_q <= vblnk;
    end

    assign frame_tick = vblnk & ~vblnk_q;

    // Load wins over a coincident tick; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (rst)                         cnt <= '0;
        else if (load)                   cnt <= load_val;
        else if (frame_tick && cnt != '0) cnt <= cnt - W'(1);
    end

    assign done = (cnt == '0);

    // Fires on the tick that brings the count to zero, so the consumer reacts one clk after vblnk rises.
    assign expire = frame_tick && (cnt <= W'(1));

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer: owns game state and scores, drives overlay state and ball hold/serve.
// Latency: every input event changes the registered outputs exactly 1 clk later.
// Backpressure: none; point pulses and start presses are acted on or dropped, never queued.
module game_ctrl
    import vga_pkg::*;
#(
    parameter int WIN_SCORE       = 5,
    parameter int SERVE_FRAMES    = 60,
    parameter int OVER_FRAMES     = 300,
    parameter int DEBOUNCE_FRAMES = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vblnk,
    input  logic               start_btn,
    input  logic               point_p1,
    input  logic               point_p2,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] player1_score,
    output logic [SCORE_W-1:0] player2_score,
    output logic               ball_hold,
    output logic               serve_dir
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
    localparam int CW         = $clog2(MAX_FRAMES + 1);
    localparam int DW_RAW     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int DW         = (DW_RAW < 1) ? 1 : DW_RAW;

    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [CW-1:0]      SERVE_LD = CW'(SERVE_FRAMES);
    localparam logic [CW-1:0]      OVER_LD  = CW'(OVER_FRAMES);
    localparam logic [DW-1:0]      LOCK_LD  = DW'(DEBOUNCE_FRAMES);

    // A 4-bit score cannot represent a winning score outside 1..15.
    if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win_score
        $error("game_ctrl: WIN_SCORE must be in 1..15");
    end

    game_state_t        state_r;
    logic [SCORE_W-1:0] p1_r;
    logic [SCORE_W-1:0] p2_r;
    logic               hold_r;
    logic               dir_r;
    logic               start_q;

    logic          start_evt;
    logic          lock_done;
    logic          lock_expire;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;
    logic          tmr_expire;
    logic          p1_only;
    logic          p2_only;
    logic          p1_win;
    logic          p2_win;
    logic          unused_timer_flags;

    // Simultaneous points cancel each other out.
    assign p1_only = point_p1 & ~point_p2;
    assign p2_only = point_p2 & ~point_p1;
    assign p1_win  = (p1_r + 4'd1) == WIN;
    assign p2_win  = (p2_r + 4'd1) == WIN;

    // Only an edge seen while the lockout is idle counts; it also re-arms the lockout in any state.
    assign start_evt = start_btn & ~start_q & lock_done;

    assign unused_timer_flags = lock_expire ^ tmr_done;

    // Remember the previous button level for edge detection.
    always_ff @(posedge clk) begin
        if (rst) start_q <= 1'b0;
        else     start_q <= start_btn;
    end

    frame_timer #(.W(DW)) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .vblnk    (vblnk),
        .load     (start_evt),
        .load_val (LOCK_LD),
        .done     (lock_done),
        .expire   (lock_expire)
    );

    // Reload the FSM frame timer on every entry to serve_wait or game_over.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SERVE_LD;
        case (state_r)
            MENU_START: begin
                if (start_evt) tmr_load = 1'b1;
            end
            GAME_PLAY: begin
                if (p1_only) begin
                    tmr_load = 1'b1;
                    if (p1_win) tmr_val = OVER_LD;
                end else if (p2_only) begin
                    tmr_load = 1'b1;
                    if (p2_win) tmr_val = OVER_LD;
                end
            end
            default: ;
        endcase
    end

    frame_timer #(.W(CW)) u_fsm_timer (
        .clk      (clk),
        .rst      (rst),
        .vblnk    (vblnk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done),
        .expire   (tmr_expire)
    );

    // Game sequencer with registered state, scores, ball hold and serve direction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MENU_START;
            p1_r    <= '0;
            p2_r    <= '0;
            hold_r  <= 1'b1;
            dir_r   <= 1'b0;
        end else begin
            case (state_r)
                MENU_START: begin
                    hold_r <= 1'b1;
                    p1_r   <= '0;
                    p2_r   <= '0;
                    if (start_evt) begin
                        state_r <= SERVE_WAIT;
                        dir_r   <= 1'b0;
                    end
                end
                SERVE_WAIT: begin
                    if (tmr_expire) begin
                        state_r <= GAME_PLAY;
                        hold_r  <= 1'b0;
                    end
                end
                GAME_PLAY: begin
                    // The scorer's opponent conceded, so the ball is launched towards the conceder.
                    if (p1_only) begin
                        p1_r    <= p1_r + 4'd1;
                        hold_r  <= 1'b1;
                        state_r <= p1_win ? GAME_OVER : SERVE_WAIT;
                        if (!p1_win) dir_r <= 1'b1;
                    end else if (p2_only) begin
                        p2_r    <= p2_r + 4'd1;
                        hold_r  <= 1'b1;
                        state_r <= p2_win ? GAME_OVER : SERVE_WAIT;
                        if (!p2_win) dir_r <= 1'b0;
                    end
                end
                GAME_OVER: begin
                    hold_r <= 1'b1;
                    if (start_evt || tmr_expire) begin
                        state_r <= MENU_START;
                        p1_r    <= '0;
                        p2_r    <= '0;
                    end
                end
                default: state_r <= MENU_START;
            endcase
        end
    end

    assign state         = state_r;
    assign player1_score = p1_r;
    assign player2_score = p2_r;
    assign ball_hold     = hold_r;
    assign serve_dir     = dir_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with WIN_SCORE=3, SERVE_FRAMES=2, OVER_FRAMES=4, DEBOUNCE_FRAMES=2.
// Inputs change 1ns after a rising edge; outputs are checked 1ns after the following edge.
// Expected values are hand-derived constants.
module tb_game_ctrl;

    logic       clk;
    logic       rst;
    logic       vblnk;
    logic       start_btn;
    logic       point_p1;
    logic       point_p2;
    logic [1:0] state;
    logic [3:0] player1_score;
    logic [3:0] player2_score;
    logic       ball_hold;
    logic       serve_dir;

    int checks = 0;
    int errors = 0;

    game_ctrl #(
        .WIN_SCORE       (3),
        .SERVE_FRAMES    (2),
        .OVER_FRAMES     (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vblnk         (vblnk),
        .start_btn     (start_btn),
        .point_p1      (point_p1),
        .point_p2      (point_p2),
        .state         (state),
        .player1_score (player1_score),
        .player2_score (player2_score),
        .ball_hold     (ball_hold),
        .serve_dir     (serve_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [3:0] s1,
                           input logic [3:0] s2, input logic hold, input logic dir);
        chk({tag, ".state"}, {2'b00, state}, {2'b00, st});
        chk({tag, ".p1"}, player1_score, s1);
        chk({tag, ".p2"}, player2_score, s2);
        chk({tag, ".hold"}, {3'b000, ball_hold}, {3'b000, hold});
        chk({tag, ".dir"}, {3'b000, serve_dir}, {3'b000, dir});
    endtask

    task automatic frame();
        vblnk = 1'b1;
        step();
        vblnk = 1'b0;
        step();
    endtask

    task automatic press();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    task automatic pt1();
        point_p1 = 1'b1;
        step();
        point_p1 = 1'b0;
    endtask

    task automatic pt2();
        point_p2 = 1'b1;
        step();
        point_p2 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vblnk = 1'b0; start_btn = 1'b0; point_p1 = 1'b0; point_p2 = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_all("reset", 2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
        step();

        // 1: start from menu, serve after two frames
        press();
        chk_all("start", 2'b11, 4'd0, 4'd0, 1'b1, 1'b0);
        step();
        frame();
        chk("serve_1frame.state", {2'b00, state}, 4'b0011);
        vblnk = 1'b1;
        step();
        chk_all("serve_done", 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
        vblnk = 1'b0;
        step();

        // 2: p2 scores, then p1 pulse during serve_wait is ignored
        pt2();
        chk_all("p2_point", 2'b11, 4'd0, 4'd1, 1'b1, 1'b0);
        pt1();
        chk_all("p1_in_serve", 2'b11, 4'd0, 4'd1, 1'b1, 1'b0);
        frame(); frame();
        chk("back_to_play", {2'b00, state}, 4'b0001);

        // 4: simultaneous points cancel
        point_p1 = 1'b1; point_p2 = 1'b1;
        step();
        point_p1 = 1'b0; point_p2 = 1'b0;
        chk_all("both_points", 2'b01, 4'd0, 4'd1, 1'b0, 1'b0);

        // 3: p1 wins, game_over times out after four frames
        pt1();
        chk_all("p1_first", 2'b11, 4'd1, 4'd1, 1'b1, 1'b1);
        frame(); frame();
        pt1();
        chk_all("p1_second", 2'b11, 4'd2, 4'd1, 1'b1, 1'b1);
        frame(); frame();
        pt1();
        chk_all("p1_win", 2'b10, 4'd3, 4'd1, 1'b1, 1'b1);
        pt2();
        chk_all("p2_in_over", 2'b10, 4'd3, 4'd1, 1'b1, 1'b1);
        frame(); frame(); frame();
        chk("over_3frames.state", {2'b00, state}, 4'b0010);
        vblnk = 1'b1;
        step();
        chk_all("over_timeout", 2'b00, 4'd0, 4'd0, 1'b1, 1'b1);
        vblnk = 1'b0;
        step();

        // 5: debounce lockout
        press();
        chk("lock_first.state", {2'b00, state}, 4'b0011);
        step();
        frame();
        press();
        chk("lock_second.state", {2'b00, state}, 4'b0011);
        step();
        frame();
        chk("lock_play.state", {2'b00, state}, 4'b0001);
        pt1(); frame(); frame();
        pt1(); frame(); frame();
        pt1();
        chk_all("lock_over", 2'b10, 4'd3, 4'd0, 1'b1, 1'b1);
        step();
        press();
        chk_all("start_in_over", 2'b00, 4'd0, 4'd0, 1'b1, 1'b1);
        step();
        frame();
        press();
        chk("locked_press.state", {2'b00, state}, 4'b0000);
        step();
        frame();
        press();
        chk_all("unlocked_press", 2'b11, 4'd0, 4'd0, 1'b1, 1'b0);
        step();
        frame(); frame();

        // 6: reset mid-game at 2:1
        pt2(); frame(); frame();
        pt1(); frame(); frame();
        pt1();
        chk_all("pre_rst_serve", 2'b11, 4'd2, 4'd1, 1'b1, 1'b1);
        frame(); frame();
        chk_all("pre_rst_play", 2'b01, 4'd2, 4'd1, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        chk_all("mid_rst", 2'b00, 4'd0, 4'd0, 1'b1, 1'b0);
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
